// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: prefix bytes, the frame state type and the key event record.
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  // Odd parity: data ones plus the parity bit must total an odd count.
  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the PS/2 pins, glitch-filters the clock and emits one strobe per filtered falling edge.
// Strobe lags the pin edge by 2+FILT_LEN cycles; data_bit holds the synchronized data seen at that edge.
module ps2_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic strobe,
  output logic data_bit
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt_clk;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (clk_s2 != filt_clk) && (cnt == CW'(FILT_LEN - 1));

  // Everything idles high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      cnt      <= '0;
      strobe   <= 1'b0;
      data_bit <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      strobe <= flip && filt_clk;
      if (flip && filt_clk) data_bit <= dat_s2;
      if (clk_s2 == filt_clk) begin
        cnt <= '0;
      end else if (flip) begin
        filt_clk <= clk_s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: frame decode, E0/F0 prefix tracking, single-entry event holding register.
// Event valid the cycle after the stop strobe; a new event while one is held and not accepted is dropped.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic [7:0] led
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          ext_flag, brk_flag;
  key_event_t    held;

  logic fall_stb, data_bit;
  logic in_stop, par_ok, tmo_hit, perr, ferr, stop_good, emit, blocked;

  ps2_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .strobe   (fall_stb),
    .data_bit (data_bit)
  );

  assign in_stop   = fall_stb && (state == ST_STOP);
  assign par_ok    = odd_parity_ok(shreg, par_bit);
  assign tmo_hit   = (state != ST_IDLE) && !fall_stb && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign ferr      = (in_stop && !data_bit) || tmo_hit;
  assign perr      = in_stop && data_bit && !par_ok;
  assign stop_good = in_stop && data_bit && par_ok;
  assign emit      = stop_good && (shreg != PREFIX_EXT) && (shreg != PREFIX_BRK);
  assign blocked   = key_valid && !key_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tmo_cnt  <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else begin
      if (state == ST_IDLE || fall_stb) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit) begin
        state <= ST_IDLE;
      end else if (fall_stb) begin
        case (state)
          ST_IDLE: if (!data_bit) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= data_bit;
            state   <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Prefixes accumulate until a real code consumes them; any error forgets them.
      if (perr || ferr) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (stop_good) begin
        if (shreg == PREFIX_EXT)      ext_flag <= 1'b1;
        else if (shreg == PREFIX_BRK) brk_flag <= 1'b1;
        else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held       <= '0;
      key_valid  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
      led        <= 8'h00;
    end else begin
      err_parity <= perr;
      err_frame  <= ferr;
      overflow   <= emit && blocked;
      if (emit && !blocked) begin
        held      <= '{code: shreg, ext: ext_flag, brk: brk_flag};
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      // The LED tracks every release seen, even one that could not be delivered.
      if (emit && brk_flag) led <= shreg;
    end
  end

  assign key_code = held.code;
  assign key_ext  = held.ext;
  assign key_brk  = held.brk;

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter FILT_LEN, default 4: consecutive equal synchronized samples required before the filtered ps2_clk changes.
REQ-002 Parameter TIMEOUT_CYC, default 5000: clk cycles allowed between falling edges inside a frame.
REQ-003 clk  in  1  system clock; single clock domain; all flops on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ps2_clk  in  1  raw keyboard clock, asynchronous to clk.
REQ-006 ps2_data  in  1  raw keyboard data, asynchronous to clk.
REQ-007 key_code  out  8  scan code of the held event.
REQ-008 key_ext  out  1  event was prefixed by 8'hE0.
REQ-009 key_brk  out  1  event was prefixed by 8'hF0 (release).
REQ-010 key_valid  out  1  held event present.
REQ-011 key_ready  in  1  consumer accepts the event when key_valid and key_ready are both high.
REQ-012 err_parity  out  1  one-cycle pulse on a parity failure.
REQ-013 err_frame  out  1  one-cycle pulse on a bad start/stop bit or a timeout.
REQ-014 overflow  out  1  one-cycle pulse when an event is dropped.
REQ-015 led  out  8  code of the last released (break) key.

Function
REQ-016 ps2_clk/ps2_data: 2-FF synchronizer each; filtered clock toggles only after FILT_LEN identical synchronized samples.
REQ-017 Falling edge of the filtered clock produces one registered strobe; data sampled from the synchronized ps2_data in that cycle; strobe lag after the pin edge at most 3+FILT_LEN cycles.
REQ-018 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: strobe with data=0 -> DATA, bit count 0; strobe with data=1 -> stay IDLE, no error.
REQ-020 DATA: shift 8 bits LSB first; after the 8th -> PARITY.
REQ-021 PARITY: record the bit -> STOP; odd parity: ones in 8 data bits plus parity bit is odd.
REQ-022 STOP: stop=1 and parity ok -> byte to decoder; parity bad -> err_parity only; stop=0 -> err_frame (takes precedence over parity); always -> IDLE.
REQ-023 Timeout: counter cleared on each strobe and in IDLE; reaching TIMEOUT_CYC outside IDLE -> IDLE, err_frame, partial byte discarded.
REQ-024 Decoder: 8'hE0 sets ext flag; 8'hF0 sets brk flag; any other byte emits {code, ext, brk} and clears both flags; err_parity or err_frame clears both flags.
REQ-025 Emit latency: key_valid high the cycle after the STOP strobe.
REQ-026 Output is a single-entry holding register; key_code/key_ext/key_brk stable while key_valid=1 and key_ready=0.
REQ-027 Emit while key_valid=1 and key_ready=0: new event dropped, overflow pulse, held event unchanged.
REQ-028 Emit in the same cycle as acceptance: new event loaded, key_valid stays 1, no overflow.
REQ-029 Acceptance with no emit: key_valid=0 next cycle.
REQ-030 led <= code on every emitted brk=1 event, including a dropped one.

Reset
REQ-031 rst clears asynchronously: FSM to IDLE, bit count 0, timeout counter 0, shift register 0, ext and brk flags 0.
REQ-032 Output reset values: key_code=0, key_ext=0, key_brk=0, key_valid=0, err_parity=0, err_frame=0, overflow=0, led=8'h00.
REQ-033 Synchronizer and filter flops reset to 1 (bus-idle level), so release of rst never produces a spurious strobe.
REQ-034 Reset mid-frame discards the frame; the next frame starting after rst deasserts decodes normally.

Structure
REQ-035 Shared package ps2_pkg: PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, frame-state enum, event struct {code, ext, brk}.
REQ-036 One sub-module ps2_filter: synchronizer, glitch filter, falling-edge strobe, synchronized-data output.

Verification
REQ-037 Frame 0x1C (start 0, data LSB first, parity 0, stop 1) -> key_valid with key_code=1C, key_ext=0, key_brk=0.
REQ-038 Frames F0, 1C -> single event with key_code=1C, key_brk=1; led=1C.
REQ-039 Frames E0, F0, 75 -> single event with key_code=75, key_ext=1, key_brk=1; led=75.
REQ-040 Frame 0x1C with parity bit 1 -> err_parity pulse, no key_valid; following good frame 0x1C decodes with key_ext=0, key_brk=0.
REQ-041 Frame stalled after 4 data bits, then TIMEOUT_CYC idle cycles -> err_frame pulse, FSM in IDLE; next frame 0x2B -> key_code=2B.
REQ-042 key_ready=0, frames 1C then 32 -> 1C held, overflow pulse, 32 dropped; raise key_ready -> key_valid falls, no further event; 1-cycle glitch on ps2_clk -> no strobe.
